// File: rtl/servo_ramp_scheduler_if.sv
// Command/status bundle between the gesture command source and the servo ramp scheduler.
// Finger i occupies bits [16i+15:16i] of both width buses.
interface servo_ramp_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [79:0] cmd_width;
  logic        abort;
  logic [79:0] width_out;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_width, abort,
    input  cmd_ready, width_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_width, abort,
    output cmd_ready, width_out, busy, done
  );
endinterface

// File: rtl/servo_ramp_scheduler.sv
// Slews five finger servo pulse widths toward clamped command targets,
// at most STEP_US per tick, with busy/done reporting and abort-to-freeze.
module servo_ramp_scheduler #(
  parameter int TICK_CYCLES = 50000,
  parameter int STEP_US     = 10,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int INIT_US     = 1500
) (
  input  logic                   clk,
  input  logic                   reset,
  servo_ramp_scheduler_if.slave  bus
);

  localparam int          CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [15:0] STEP      = 16'(STEP_US);
  localparam logic [15:0] MIN_W     = 16'(MIN_US);
  localparam logic [15:0] MAX_W     = 16'(MAX_US);
  localparam logic [15:0] INIT_W    = 16'(INIT_US);

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    tick_cnt;
  logic [4:0][15:0] width_q;
  logic [4:0][15:0] target_q;
  logic             all_at_target;
  logic             tick;

  function automatic logic [15:0] clamp(input logic [15:0] w);
    if (w < MIN_W)      return MIN_W;
    else if (w > MAX_W) return MAX_W;
    else                return w;
  endfunction

  // Moves one finger by at most STEP toward its target, landing exactly on it.
  function automatic logic [15:0] step_toward(input logic [15:0] w, input logic [15:0] t);
    logic [15:0] diff;
    diff = '0;
    if (w < t) begin
      diff = t - w;
      return (diff > STEP) ? w + STEP : t;
    end else if (w > t) begin
      diff = w - t;
      return (diff > STEP) ? w - STEP : t;
    end
    return w;
  endfunction

  // NOTE: combinational outputs get a default before any conditional update,
  // so every path assigns them and no latch is inferred.
  always_comb begin
    all_at_target = 1'b1;
    for (int i = 0; i < 5; i++)
      if (width_q[i] != target_q[i]) all_at_target = 1'b0;
  end

  assign tick          = (tick_cnt == TICK_LAST);
  assign bus.width_out = width_q;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      // NOTE: the target bank is a handful of flops, not a RAM, and the
      // all-at-target compare reads it, so it is reset along with the widths.
      for (int i = 0; i < 5; i++) begin
        width_q[i]  <= INIT_W;
        target_q[i] <= INIT_W;
      end
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            for (int i = 0; i < 5; i++)
              target_q[i] <= clamp(bus.cmd_width[16*i +: 16]);
            tick_cnt      <= '0;
            state         <= RAMP;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        RAMP: begin
          tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
          // Abort outranks a coincident tick: the hand freezes where it is.
          if (bus.abort) begin
            target_q <= width_q;
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (all_at_target) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (tick) begin
            for (int i = 0; i < 5; i++)
              width_q[i] <= step_toward(width_q[i], target_q[i]);
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Directed bench for servo_ramp_scheduler with TICK_CYCLES=4, STEP_US=100:
// table of ramp commands plus hand sequences for abort, handshake and async reset.
module tb_servo_ramp_scheduler;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  servo_ramp_scheduler_if bus ();

  servo_ramp_scheduler #(
    .TICK_CYCLES(4),
    .STEP_US    (100),
    .MIN_US     (1000),
    .MAX_US     (2000),
    .INIT_US    (1500)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [79:0] cmd;
    int          chk_cyc;
    logic [79:0] chk_w;
    logic [79:0] final_w;
    int          done_cyc;
  } vec_t;

  vec_t        vecs [5];
  logic [79:0] cur_w;

  function automatic logic [79:0] pack(input int t, input int i, input int m,
                                       input int r, input int p);
    return {16'(p), 16'(r), 16'(m), 16'(i), 16'(t)};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues cmd in the current cycle (cycle 0) and checks the ramp against v.
  task automatic apply_vec(input vec_t v);
    bus.cmd_width = v.cmd;
    bus.cmd_valid = 1'b1;
    check($sformatf("%s ready_at_accept", v.name), 80'(bus.cmd_ready), 80'(1));
    for (int c = 1; c <= v.done_cyc + 1; c++) begin
      next_cycle();
      if (c == 1) bus.cmd_valid = 1'b0;
      check($sformatf("%s done c%0d", v.name, c), 80'(bus.done), 80'(c == v.done_cyc));
      if (c == 4 && v.done_cyc > 5)
        check($sformatf("%s no_step_before_tick", v.name), bus.width_out, cur_w);
      if (c == v.chk_cyc)
        check($sformatf("%s width c%0d", v.name, c), bus.width_out, v.chk_w);
      if (c == v.done_cyc - 1) begin
        check($sformatf("%s final_width", v.name), bus.width_out, v.final_w);
        check($sformatf("%s busy_in_ramp", v.name), 80'(bus.busy), 80'(1));
      end
      if (c == v.done_cyc + 1) begin
        check($sformatf("%s ready_after", v.name), 80'(bus.cmd_ready), 80'(1));
        check($sformatf("%s busy_after", v.name), 80'(bus.busy), 80'(0));
      end
    end
    cur_w = v.final_w;
  endtask

  initial begin
    vec_t fup;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"pinky_down", pack(1500,1500,1500,1500,1000), 5,
                pack(1500,1500,1500,1500,1400), pack(1500,1500,1500,1500,1000), 22};
    vecs[1] = '{"clamp_high", pack(2050,1450,1500,1500,1500), 5,
                pack(1600,1450,1500,1500,1100), pack(2000,1450,1500,1500,1500), 22};
    vecs[2] = '{"zero_motion", pack(2000,1450,1500,1500,1500), 1,
                pack(2000,1450,1500,1500,1500), pack(2000,1450,1500,1500,1500), 2};
    vecs[3] = '{"clamp_low_mix", pack(1990,1450,500,1730,1500), 9,
                pack(1990,1450,1300,1700,1500), pack(1990,1450,1000,1730,1500), 22};
    vecs[4] = '{"clamp_ffff", pack(65535,1450,1000,1730,1500), 5,
                pack(2000,1450,1000,1730,1500), pack(2000,1450,1000,1730,1500), 6};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_width = '0;
    bus.abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) next_cycle();
    cur_w = pack(1500,1500,1500,1500,1500);
    check("reset width", bus.width_out, cur_w);
    check("reset ready", 80'(bus.cmd_ready), 80'(1));
    check("reset busy", 80'(bus.busy), 80'(0));
    check("reset done", 80'(bus.done), 80'(0));

    foreach (vecs[k]) apply_vec(vecs[k]);

    // Abort on the tick cycle that would have stepped pinky 1300 -> 1200.
    bus.cmd_width = pack(2000,1450,1000,1730,1000);
    bus.cmd_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      if (c == 1) bus.cmd_valid = 1'b0;
      if (c == 12) bus.abort = 1'b1;
      check($sformatf("abort done c%0d", c), 80'(bus.done), 80'(c == 13));
      if (c == 9 || c >= 12)
        check($sformatf("abort width c%0d", c), bus.width_out, pack(2000,1450,1000,1730,1300));
      if (c == 14) begin
        check("abort ready", 80'(bus.cmd_ready), 80'(1));
        check("abort busy", 80'(bus.busy), 80'(0));
      end
    end
    bus.abort = 1'b0;
    cur_w = pack(2000,1450,1000,1730,1300);
    fup = '{"after_abort", pack(2000,1450,1000,1730,1500), 5,
            pack(2000,1450,1000,1730,1400), pack(2000,1450,1000,1730,1500), 10};
    apply_vec(fup);

    // New data held on cmd_valid through a ramp is taken once, on return to IDLE.
    bus.cmd_width = pack(2000,1550,1000,1730,1500);
    bus.cmd_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 1) bus.cmd_width = pack(2000,1550,1000,1830,1500);
      check($sformatf("hs done c%0d", c), 80'(bus.done), 80'(c == 6 || c == 13));
      if (c == 5) check("hs first_cmd width", bus.width_out, pack(2000,1550,1000,1730,1500));
      if (c == 7) check("hs ready_c7", 80'(bus.cmd_ready), 80'(1));
      if (c == 8) begin
        check("hs ready_c8", 80'(bus.cmd_ready), 80'(0));
        check("hs busy_c8", 80'(bus.busy), 80'(1));
        bus.cmd_valid = 1'b0;
      end
      if (c == 12) check("hs second_cmd width", bus.width_out, pack(2000,1550,1000,1830,1500));
      if (c >= 14) check($sformatf("hs idle busy c%0d", c), 80'(bus.busy), 80'(0));
    end

    // Asynchronous reset mid-ramp, between clock edges.
    bus.cmd_width = pack(2000,1550,1000,1830,1000);
    bus.cmd_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (c == 1) bus.cmd_valid = 1'b0;
      if (c == 13) check("rst pre width", bus.width_out, pack(2000,1550,1000,1830,1200));
    end
    #2 reset = 1'b1;
    #1;
    check("rst async width", bus.width_out, pack(1500,1500,1500,1500,1500));
    check("rst async ready", 80'(bus.cmd_ready), 80'(1));
    check("rst async busy", 80'(bus.busy), 80'(0));
    check("rst async done", 80'(bus.done), 80'(0));
    reset = 1'b0;
    repeat (2) next_cycle();
    check("rst post ready", 80'(bus.cmd_ready), 80'(1));
    check("rst post busy", 80'(bus.busy), 80'(0));
    check("rst post width", bus.width_out, pack(1500,1500,1500,1500,1500));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_ramp_scheduler.md
Name: servo_ramp_scheduler

Overview:
- Sits between the gesture command source and the five finger servo PWM generators. It owns the per-finger pulse widths fed to those generators.
- Accepts a full 5-finger target-width command over a valid/ready handshake and clamps each target to the safe servo range.
- Slews every finger toward its target at a bounded rate (STEP_US per tick). This prevents step jumps, current spikes and mechanical shock.
- Reports busy/done to the command source, and supports abort to freeze the hand in place.

Parameters:
- TICK_CYCLES, 50000, clk cycles per slew tick (1 ms at 50 MHz); must be >=1.
- STEP_US, 10, maximum width change per finger per tick, in µs; must be >=1.
- MIN_US, 1000, lower clamp for any target width.
- MAX_US, 2000, upper clamp for any target width.
- INIT_US, 1500, reset width for all fingers; MIN_US <= INIT_US <= MAX_US.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present; source holds cmd_width stable until accepted.
- cmd_ready  out  1  block can accept a command.
- cmd_width  in  80  target widths in µs: finger i at [16i+15:16i]; 0=thumb, 1=index, 2=middle, 3=ring, 4=pinky.
- abort  in  1  stop motion; freeze at current widths.
- width_out  out  80  current widths to the PWM generators; same packing as cmd_width.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a command completes or is aborted.

Behaviour:
- Reset (asynchronous, immediate):
  - every width_out field = INIT_US; internal targets = INIT_US.
  - state = IDLE, tick counter = 0.
  - cmd_ready = 1, busy = 0, done = 0.
  - Applies identically mid-RAMP: widths snap to INIT_US.
- States: IDLE, RAMP, DONE. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - Accept occurs on a cycle with cmd_valid && cmd_ready. On accept: latch the clamped targets (below MIN_US -> MIN_US, above MAX_US -> MAX_US, unsigned 16-bit compare), clear the tick counter, and go to RAMP.
  - cmd_ready is 0 from the cycle after accept.
- RAMP:
  - The tick counter runs 0..TICK_CYCLES-1 and wraps; a tick is the cycle where counter == TICK_CYCLES-1.
  - On a tick, each finger whose width != target moves toward the target by min(STEP_US, |target - width|). The step never overshoots.
  - Fingers move concurrently and independently; a finger already at target holds.
  - width_out changes only on tick edges.
  - If all five widths equal their targets in any RAMP cycle, the next state is DONE. No tick wait is needed for this check.
- DONE: done = 1 for exactly this one cycle, then IDLE.
- abort:
  - Sampled only in RAMP. It sets targets := current widths and the next state is DONE.
  - abort on a tick cycle: abort wins and no step is applied.
  - abort in IDLE or DONE is ignored.
- cmd_valid while cmd_ready = 0 is neither accepted nor lost; the source keeps holding the command.
- Arithmetic: 16-bit unsigned; operands are within MIN_US..MAX_US, so no wrap-around is possible.
- Timing, with the accept cycle = cycle 0:
  - RAMP runs from cycle 1, with counter = 0 in cycle 1.
  - The first step is visible at cycle TICK_CYCLES+1.
  - After the last step becomes visible at cycle V: DONE at V+1, IDLE with cmd_ready = 1 at V+2.
  - Zero-motion command: RAMP at 1, DONE at 2, IDLE at 3.

Test Plan (TICK_CYCLES=4, STEP_US=100, other parameters default):
- Reset, then idle 10 cycles -> every width_out field = 1500, cmd_ready = 1, busy = 0, done = 0.
- Command pinky = 1000, others = 1500 (accept at cycle 0):
  - pinky steps 1400, 1300, 1200, 1100, 1000, visible at cycles 5, 9, 13, 17, 21.
  - done pulses at cycle 22 only; cmd_ready = 1 at cycle 23; the other fingers stay at 1500.
- Command thumb = 2050, index = 1450, others = 1500:
  - thumb is clamped to 2000 and steps 1600..2000 (5 ticks).
  - index reaches 1450 in one partial step at cycle 5.
  - done pulses at cycle 22.
- Pinky ramp toward 1000, abort asserted after width reaches 1300 and held across the next tick -> pinky frozen at 1300, one-cycle done pulse, IDLE. A following command to 1500 ramps up from 1300.
- Handshake:
  - cmd_valid with new data held throughout a RAMP -> not accepted until IDLE, then accepted exactly once.
  - Command equal to current widths -> done at cycle 2 after accept, width_out unchanged.
- Assert reset asynchronously mid-RAMP (pinky at 1200) -> all widths 1500 with no clock edge needed; state IDLE, cmd_ready = 1 after release.
